// File: rtl/soc_msp430_dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   owner_t    : which requester owned the memory in the previous cycle.
//                This selects where the registered read data is returned.
//   WAIT_CNT_W : width of the DMA starvation wait counter.
package soc_msp430_dmem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_CPU    = 2'd1,
        OWN_DMA_RD = 2'd2
    } owner_t;

    localparam int WAIT_CNT_W = 8;

endpackage

// File: rtl/soc_msp430_arb_starve_cnt.sv
// Saturating wait counter that tracks how long the DMA requester has been
// refused access, plus a threshold flag.
//   mclk, reset_n : clock, async active-low reset
//   dma_req       : DMA request
//   dma_gnt       : DMA grant issued this cycle
//   dma_starve    : high while the counter sits at DMA_MAX_WAIT
module soc_msp430_arb_starve_cnt
    import soc_msp430_dmem_arb_pkg::*;
#(
    parameter int DMA_MAX_WAIT = 8
) (
    input  logic mclk,
    input  logic reset_n,
    input  logic dma_req,
    input  logic dma_gnt,
    output logic dma_starve
);

    localparam logic [WAIT_CNT_W-1:0] MAX_WAIT = WAIT_CNT_W'(DMA_MAX_WAIT);

    logic [WAIT_CNT_W-1:0] wait_cnt;

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n)
            wait_cnt <= '0;
        else if (!dma_req || dma_gnt)
            wait_cnt <= '0;
        else if (wait_cnt != MAX_WAIT)
            wait_cnt <= wait_cnt + 1'b1;
    end

    // The flag is a decode of the counter register, so it is already
    // registered. It drops in the cycle after the grant clears the counter.
    assign dma_starve = (wait_cnt == MAX_WAIT);

endmodule

// File: rtl/soc_msp430_dmem_arbiter.sv
// Shares the single-port data memory between the CPU (absolute priority,
// never stalled) and a DMA-style requester served only in CPU-idle cycles.
//   mclk, reset_n          : clock, async active-low reset
//   cpu_dmem_*             : CPU data-memory bus (cen/wen active low)
//   dma_req/addr/din/we    : DMA request (we active high, 2'b00 = read)
//   dma_gnt                : DMA access accepted this cycle
//   dma_rvalid/dma_rdata   : DMA read return, one cycle after the grant
//   dma_starve             : DMA has waited DMA_MAX_WAIT cycles
//   dmem_*                 : physical memory port (dout valid one cycle later)
module soc_msp430_dmem_arbiter
    import soc_msp430_dmem_arb_pkg::*;
#(
    parameter int DMEM_AW      = 10,
    parameter int DMA_MAX_WAIT = 8
) (
    input  logic               mclk,
    input  logic               reset_n,
    input  logic [DMEM_AW-1:0] cpu_dmem_addr,
    input  logic               cpu_dmem_cen,
    input  logic [15:0]        cpu_dmem_din,
    input  logic [1:0]         cpu_dmem_wen,
    output logic [15:0]        cpu_dmem_dout,
    input  logic               dma_req,
    input  logic [DMEM_AW-1:0] dma_addr,
    input  logic [15:0]        dma_din,
    input  logic [1:0]         dma_we,
    output logic               dma_gnt,
    output logic               dma_rvalid,
    output logic [15:0]        dma_rdata,
    output logic               dma_starve,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic               dmem_cen,
    output logic [15:0]        dmem_din,
    output logic [1:0]         dmem_wen,
    input  logic [15:0]        dmem_dout
);

    owner_t      owner, owner_nxt;
    logic [15:0] rdata_q;
    logic [15:0] cpu_q;
    logic        cpu_acc;

    assign cpu_acc = ~cpu_dmem_cen;

    // The grant is masked during reset so that a waiting requester does not
    // see a grant that the owner register cannot record.
    assign dma_gnt = dma_req & cpu_dmem_cen & reset_n;

    // Memory port mux. When the port is idle, address and data stay at the CPU
    // values so that they do not toggle without a reason.
    always_comb begin
        dmem_addr = cpu_dmem_addr;
        dmem_din  = cpu_dmem_din;
        dmem_cen  = 1'b1;
        dmem_wen  = 2'b11;
        if (cpu_acc) begin
            dmem_cen = cpu_dmem_cen;
            dmem_wen = cpu_dmem_wen;
        end else if (dma_gnt) begin
            dmem_addr = dma_addr;
            dmem_din  = dma_din;
            dmem_cen  = 1'b0;
            dmem_wen  = ~dma_we;
        end
    end

    always_comb begin
        owner_nxt = OWN_NONE;
        if (cpu_acc)
            owner_nxt = OWN_CPU;
        else if (dma_gnt && dma_we == 2'b00)
            owner_nxt = OWN_DMA_RD;
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            owner   <= OWN_NONE;
            rdata_q <= '0;
            cpu_q   <= '0;
        end else begin
            owner <= owner_nxt;
            if (owner == OWN_DMA_RD)
                rdata_q <= dmem_dout;
            if (owner == OWN_CPU)
                cpu_q <= dmem_dout;
        end
    end

    // Read return. Each side sees live memory data only in the cycle after its
    // own access. Otherwise it sees its last held value, so the two requesters
    // never observe each other's traffic.
    assign dma_rvalid    = (owner == OWN_DMA_RD);
    assign dma_rdata     = (owner == OWN_DMA_RD) ? dmem_dout : rdata_q;
    assign cpu_dmem_dout = (owner == OWN_CPU)    ? dmem_dout : cpu_q;

    soc_msp430_arb_starve_cnt #(
        .DMA_MAX_WAIT(DMA_MAX_WAIT)
    ) u_starve (
        .mclk      (mclk),
        .reset_n   (reset_n),
        .dma_req   (dma_req),
        .dma_gnt   (dma_gnt),
        .dma_starve(dma_starve)
    );

endmodule

// File: tb/tb_soc_msp430_dmem_arbiter.sv
module tb_soc_msp430_dmem_arbiter;

    localparam int AW = 10;

    logic          mclk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] cpu_dmem_addr;
    logic          cpu_dmem_cen;
    logic [15:0]   cpu_dmem_din;
    logic [1:0]    cpu_dmem_wen;
    logic [15:0]   cpu_dmem_dout;
    logic          dma_req;
    logic [AW-1:0] dma_addr;
    logic [15:0]   dma_din;
    logic [1:0]    dma_we;
    logic          dma_gnt;
    logic          dma_rvalid;
    logic [15:0]   dma_rdata;
    logic          dma_starve;
    logic [AW-1:0] dmem_addr;
    logic          dmem_cen;
    logic [15:0]   dmem_din;
    logic [1:0]    dmem_wen;
    logic [15:0]   dmem_dout;

    int checks   = 0;
    int failures = 0;

    always #5 mclk = ~mclk;

    soc_msp430_dmem_arbiter #(.DMEM_AW(AW), .DMA_MAX_WAIT(8)) dut (
        .mclk(mclk), .reset_n(reset_n),
        .cpu_dmem_addr(cpu_dmem_addr), .cpu_dmem_cen(cpu_dmem_cen),
        .cpu_dmem_din(cpu_dmem_din), .cpu_dmem_wen(cpu_dmem_wen),
        .cpu_dmem_dout(cpu_dmem_dout),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_din(dma_din), .dma_we(dma_we),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .dma_starve(dma_starve),
        .dmem_addr(dmem_addr), .dmem_cen(dmem_cen), .dmem_din(dmem_din),
        .dmem_wen(dmem_wen), .dmem_dout(dmem_dout)
    );

    // Single-port synchronous memory: byte writes, one-cycle read data
    logic [15:0] mem [0:(1<<AW)-1];
    always @(posedge mclk) begin
        if (!dmem_cen) begin
            dmem_dout <= mem[dmem_addr];
            if (!dmem_wen[0]) mem[dmem_addr][7:0]  <= dmem_din[7:0];
            if (!dmem_wen[1]) mem[dmem_addr][15:8] <= dmem_din[15:8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // inputs change 1 time unit after the rising edge; checks follow at +1
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge mclk);
            #1;
        end
    endtask

    task automatic cpu_wr(input logic [AW-1:0] a, input logic [15:0] d);
        cpu_dmem_cen = 1'b0; cpu_dmem_wen = 2'b00; cpu_dmem_addr = a; cpu_dmem_din = d;
        tick(1);
        cpu_dmem_cen = 1'b1; cpu_dmem_wen = 2'b11;
    endtask

    initial begin
        dmem_dout     = '0;
        reset_n       = 1'b0;
        cpu_dmem_addr = '0; cpu_dmem_cen = 1'b1; cpu_dmem_din = '0; cpu_dmem_wen = 2'b11;
        dma_req = 1'b1; dma_addr = '0; dma_din = '0; dma_we = 2'b00;

        // reset with a pending DMA request
        tick(2);
        chk("rst_dmem_cen",  dmem_cen,      1);
        chk("rst_dmem_wen",  dmem_wen,      2'b11);
        chk("rst_gnt",       dma_gnt,       0);
        chk("rst_rvalid",    dma_rvalid,    0);
        chk("rst_starve",    dma_starve,    0);
        chk("rst_rdata",     dma_rdata,     0);
        chk("rst_cpu_dout",  cpu_dmem_dout, 0);

        dma_req = 1'b0;
        reset_n = 1'b1;
        tick(1);
        cpu_wr(10'h020, 16'h1234);
        cpu_wr(10'h030, 16'h5A5A);
        cpu_wr(10'h040, 16'hFFFF);
        tick(1);

        // DMA write, CPU idle
        dma_req = 1'b1; dma_addr = 10'h012; dma_din = 16'hBEEF; dma_we = 2'b11;
        #1;
        chk("wr_gnt",       dma_gnt,   1);
        chk("wr_dmem_cen",  dmem_cen,  0);
        chk("wr_dmem_addr", dmem_addr, 10'h012);
        chk("wr_dmem_wen",  dmem_wen,  2'b00);
        chk("wr_dmem_din",  dmem_din,  16'hBEEF);
        tick(1);
        dma_req = 1'b0;
        #1;
        chk("wr_no_rvalid", dma_rvalid, 0);

        // DMA read of the word just written
        dma_req = 1'b1; dma_we = 2'b00;
        #1;
        chk("rd_gnt",      dma_gnt,  1);
        chk("rd_dmem_wen", dmem_wen, 2'b11);
        tick(1);
        dma_req = 1'b0;
        #1;
        chk("rd_rvalid", dma_rvalid, 1);
        chk("rd_rdata",  dma_rdata,  16'hBEEF);
        tick(4);
        chk("rd_rvalid_drop", dma_rvalid, 0);
        chk("rd_rdata_hold",  dma_rdata,  16'hBEEF);

        // collision: CPU read of 0x020 against a DMA read of 0x012
        cpu_dmem_cen = 1'b0; cpu_dmem_wen = 2'b11; cpu_dmem_addr = 10'h020;
        dma_req = 1'b1; dma_addr = 10'h012; dma_we = 2'b00;
        #1;
        chk("col_gnt",       dma_gnt,   0);
        chk("col_dmem_addr", dmem_addr, 10'h020);
        chk("col_dmem_cen",  dmem_cen,  0);
        tick(1);
        cpu_dmem_cen = 1'b1;
        #1;
        chk("col_cpu_dout", cpu_dmem_dout, 16'h1234);
        chk("col_gnt_next", dma_gnt,       1);
        chk("col_dma_addr", dmem_addr,     10'h012);
        tick(1);
        dma_req = 1'b0;
        #1;
        chk("col_rvalid",    dma_rvalid,    1);
        chk("col_rdata",     dma_rdata,     16'hBEEF);
        chk("col_cpu_hold",  cpu_dmem_dout, 16'h1234);

        // starvation: the CPU reads 0x030 for 10 cycles while the DMA waits to read 0x040
        cpu_dmem_cen = 1'b0; cpu_dmem_addr = 10'h030;
        dma_req = 1'b1; dma_addr = 10'h040;
        tick(7);
        chk("stv_7",      dma_starve, 0);
        chk("stv_7_gnt",  dma_gnt,    0);
        tick(1);
        chk("stv_8",      dma_starve, 1);
        tick(2);
        chk("stv_10",     dma_starve, 1);
        cpu_dmem_cen = 1'b1;
        #1;
        chk("stv_gnt",       dma_gnt,       1);
        chk("stv_gnt_flag",  dma_starve,    1);
        chk("stv_cpu_dout",  cpu_dmem_dout, 16'h5A5A);
        tick(1);
        dma_req = 1'b0;
        #1;
        chk("stv_clear",     dma_starve,    0);
        chk("iso_rvalid",    dma_rvalid,    1);
        chk("iso_rdata",     dma_rdata,     16'hFFFF);
        chk("iso_cpu_dout",  cpu_dmem_dout, 16'h5A5A);

        // short wait (below the threshold), then the request is dropped: the counter must clear
        cpu_dmem_cen = 1'b0; dma_req = 1'b1;
        tick(5);
        dma_req = 1'b0;
        tick(1);
        dma_req = 1'b1;
        tick(7);
        chk("stv_drop_clr", dma_starve, 0);
        cpu_dmem_cen = 1'b1;
        dma_req = 1'b0;
        tick(1);

        // reset asserted on a DMA read grant cycle
        dma_req = 1'b1; dma_addr = 10'h012; dma_we = 2'b00;
        #1;
        chk("rstrd_gnt", dma_gnt, 1);
        reset_n = 1'b0;
        tick(1);
        chk("rstrd_rvalid", dma_rvalid, 0);
        chk("rstrd_rdata",  dma_rdata,  0);
        dma_req = 1'b0;
        reset_n = 1'b1;
        tick(1);
        chk("rstrd_rvalid2", dma_rvalid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
